// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for seq_alu and its shift-step helper.
//   op_e    : 3-bit operation encoding presented on OP
//   state_e : sequencer states
//   is_shift: true for the three iterative shift operations
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_SAR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: combinational single-bit shift.
//   din     in   WIDTH  value to shift
//   mode    in   op_e   OP_SHL (zero fill), OP_SHR (zero fill), OP_SAR (sign fill);
//                       any other op passes din through with bit_out=0
//   dout    out  WIDTH  shifted value
//   bit_out out  1      bit shifted out
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  op_e              mode,
    output logic [WIDTH-1:0] dout,
    output logic             bit_out
);

    always_comb begin
        dout    = din;
        bit_out = 1'b0;
        case (mode)
            OP_SHL: begin
                dout    = {din[WIDTH-2:0], 1'b0};
                bit_out = din[WIDTH-1];
            end
            OP_SHR: begin
                dout    = {1'b0, din[WIDTH-1:1]};
                bit_out = din[0];
            end
            OP_SAR: begin
                dout    = {din[WIDTH-1], din[WIDTH-1:1]};
                bit_out = din[0];
            end
            default: begin
                dout    = din;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with valid/ready handshakes on both sides.
//   CLK, RST_N           clock (rising edge), async active-low reset
//   IN_VALID/IN_READY    request handshake; IN_READY high only in IDLE
//   A, B, OP             operands and operation (B[SHAMT_W-1:0] = shift amount)
//   OUT_VALID/OUT_READY  result handshake; result held until OUT_READY
//   Y, C, V, N, Z        registered result and carry/overflow/negative/zero flags
// ADD/SUB/logic complete one cycle after accept; shifts take one cycle per bit.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z
);

    state_e               state;
    op_e                  op_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [WIDTH-1:0]     shv;
    logic [SHAMT_W-1:0]   cnt;
    logic                 v_acc;

    op_e                  op_in;
    logic                 shift_active;
    logic                 op_is_sub;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     exec_y;
    logic                 exec_c;
    logic                 exec_v;
    logic [WIDTH-1:0]     step_y;
    logic                 step_out;
    logic                 step_v;

    assign op_in = op_e'(OP);

    alu_shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .din     (shv),
        .mode    (op_r),
        .dout    (step_y),
        .bit_out (step_out)
    );

    // SHL overflow: MSB flips on this step
    assign step_v       = (op_r == OP_SHL) && (step_y[WIDTH-1] != shv[WIDTH-1]);
    assign shift_active = is_shift(op_r) && (b_r[SHAMT_W-1:0] != '0);

    // Single adder: SUB is A + ~B + 1, so C=1 means no borrow.
    always_comb begin
        op_is_sub = (op_r == OP_SUB);
        addend    = op_is_sub ? ~b_r : b_r;
        sum       = {1'b0, a_r} + {1'b0, addend} + (WIDTH+1)'(op_is_sub);
        exec_y    = a_r;
        exec_c    = 1'b0;
        exec_v    = 1'b0;
        case (op_r)
            OP_ADD, OP_SUB: begin
                exec_y = sum[WIDTH-1:0];
                exec_c = sum[WIDTH];
                // operands (after inversion) agree in sign but result does not
                exec_v = (a_r[WIDTH-1] == addend[WIDTH-1]) &&
                         (sum[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_AND: exec_y = a_r & b_r;
            OP_OR:  exec_y = a_r | b_r;
            OP_XOR: exec_y = a_r ^ b_r;
            default: begin
                // shift by zero: value passes through, C=V=0
                exec_y = a_r;
            end
        endcase
    end

    // ST_SHIFT doubles as the one-cycle execute state for non-shift ops and
    // zero-amount shifts: they enter it with cnt=1 and finish on the next edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            op_r      <= OP_ADD;
            a_r       <= '0;
            b_r       <= '0;
            shv       <= '0;
            cnt       <= '0;
            v_acc     <= 1'b0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            Y         <= '0;
            C         <= 1'b0;
            V         <= 1'b0;
            N         <= 1'b0;
            Z         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        a_r      <= A;
                        b_r      <= B;
                        op_r     <= op_in;
                        shv      <= A;
                        v_acc    <= 1'b0;
                        cnt      <= (is_shift(op_in) && (B[SHAMT_W-1:0] != '0))
                                    ? B[SHAMT_W-1:0] : SHAMT_W'(1);
                        IN_READY <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (shift_active) begin
                        if (cnt == SHAMT_W'(1)) begin
                            Y         <= step_y;
                            C         <= step_out;
                            V         <= v_acc | step_v;
                            N         <= step_y[WIDTH-1];
                            Z         <= (step_y == '0);
                            OUT_VALID <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            shv   <= step_y;
                            v_acc <= v_acc | step_v;
                            cnt   <= cnt - 1'b1;
                        end
                    end else begin
                        Y         <= exec_y;
                        C         <= exec_c;
                        V         <= exec_v;
                        N         <= exec_y[WIDTH-1];
                        Z         <= (exec_y == '0);
                        OUT_VALID <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    OUT_VALID <= 1'b0;
                    IN_READY  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=8.
module tb_seq_alu;

    localparam logic [2:0] T_ADD = 3'b000;
    localparam logic [2:0] T_SUB = 3'b001;
    localparam logic [2:0] T_AND = 3'b010;
    localparam logic [2:0] T_OR  = 3'b011;
    localparam logic [2:0] T_XOR = 3'b100;
    localparam logic [2:0] T_SHL = 3'b101;
    localparam logic [2:0] T_SHR = 3'b110;
    localparam logic [2:0] T_SAR = 3'b111;

    typedef struct {
        logic [7:0] y;
        logic [3:0] f;    // {C,V,N,Z}
        int         lat;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] OP;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] Y;
    logic       C;
    logic       V;
    logic       N;
    logic       Z;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    seq_alu #(
        .WIDTH (8)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Y         (Y),
        .C         (C),
        .V         (V),
        .N         (N),
        .Z         (Z)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t       e;
        logic [8:0] s;
        logic [7:0] y;
        logic [7:0] nv;
        logic       c;
        logic       v;
        int         k;
        c     = 1'b0;
        v     = 1'b0;
        y     = 8'h00;
        e.lat = 1;
        case (op)
            T_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (y[7] != a[7]);
            end
            T_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 9'd1;
                y = s[7:0];
                c = s[8];
                v = (a[7] != b[7]) && (y[7] != a[7]);
            end
            T_AND: y = a & b;
            T_OR:  y = a | b;
            T_XOR: y = a ^ b;
            default: begin
                k = int'(b[2:0]);
                y = a;
                for (int i = 0; i < k; i++) begin
                    if (op == T_SHL) begin
                        c  = y[7];
                        nv = y << 1;
                        if (nv[7] != y[7]) v = 1'b1;
                    end else if (op == T_SHR) begin
                        c  = y[0];
                        nv = y >> 1;
                    end else begin
                        c  = y[0];
                        nv = {y[7], y[7:1]};
                    end
                    y = nv;
                end
                if (k > 0) e.lat = k;
            end
        endcase
        e.y = y;
        e.f = {c, v, y[7], (y == 8'h00)};
        return e;
    endfunction

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        A        = a;
        B        = b;
        OP       = op;
        IN_VALID = 1'b1;
        check_eq("in_ready_before_accept", IN_READY, 1'b1);
        sb.push_back(model(a, b, op));
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic wait_result();
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!OUT_VALID && cyc < 40) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check_eq("out_valid_seen", OUT_VALID, 1'b1);
        if (sb.size() == 0) begin
            check_eq("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check_eq("latency", cyc, e.lat);
            check_eq("y", Y, e.y);
            check_eq("flags_cvnz", {C, V, N, Z}, e.f);
            check_eq("in_ready_done", IN_READY, 1'b0);
        end
    endtask

    task automatic release_out();
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check_eq("out_valid_clear", OUT_VALID, 1'b0);
        check_eq("in_ready_idle", IN_READY, 1'b1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        start_op(a, b, op);
        wait_result();
        release_out();
    endtask

    initial begin
        logic [7:0] hold_y;
        logic [3:0] hold_f;

        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        A         = '0;
        B         = '0;
        OP        = '0;
        #12;
        check_eq("reset_y", Y, 8'h00);
        check_eq("reset_flags", {C, V, N, Z}, 4'h0);
        check_eq("reset_out_valid", OUT_VALID, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check_eq("reset_in_ready", IN_READY, 1'b1);

        // directed cases
        run_op(8'h7F, 8'h01, T_ADD);
        run_op(8'h05, 8'h05, T_SUB);
        run_op(8'h00, 8'h01, T_SUB);
        run_op(8'h81, 8'h03, T_SHL);
        run_op(8'h5A, 8'h00, T_SHL);
        run_op(8'h80, 8'h07, T_SAR);
        run_op(8'h80, 8'h07, T_SHR);
        run_op(8'hF0, 8'h3C, T_AND);
        run_op(8'hF0, 8'h0C, T_OR);
        run_op(8'hAA, 8'hAA, T_XOR);
        run_op(8'h40, 8'h01, T_SHL);
        run_op(8'h80, 8'h80, T_ADD);

        // random mix
        for (int i = 0; i < 24; i++) begin
            run_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
        end

        // stalled consumer with a competing request
        start_op(8'h11, 8'h22, T_ADD);
        wait_result();
        hold_y   = Y;
        hold_f   = {C, V, N, Z};
        A        = 8'h40;
        B        = 8'h03;
        OP       = T_SUB;
        IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            check_eq("stall_out_valid", OUT_VALID, 1'b1);
            check_eq("stall_in_ready", IN_READY, 1'b0);
            check_eq("stall_y", Y, hold_y);
            check_eq("stall_flags", {C, V, N, Z}, hold_f);
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check_eq("handoff_out_valid", OUT_VALID, 1'b0);
        check_eq("handoff_in_ready", IN_READY, 1'b1);
        check_eq("idle_y_held", Y, hold_y);
        sb.push_back(model(8'h40, 8'h03, T_SUB));
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        check_eq("late_accept_in_ready", IN_READY, 1'b0);
        wait_result();
        release_out();

        // reset during a shift
        A        = 8'h01;
        B        = 8'h07;
        OP       = T_SHL;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("abort_y", Y, 8'h00);
        check_eq("abort_flags", {C, V, N, Z}, 4'h0);
        check_eq("abort_out_valid", OUT_VALID, 1'b0);
        repeat (2) begin
            @(posedge CLK);
            #1;
            check_eq("abort_hold_out_valid", OUT_VALID, 1'b0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            check_eq("post_abort_no_result", OUT_VALID, 1'b0);
        end
        check_eq("post_abort_in_ready", IN_READY, 1'b1);
        run_op(8'h01, 8'h01, T_ADD);

        check_eq("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
